// File: rtl/alu_op_checker.sv
// Drives an external combinational ALU for one requested operation, waits for it
// to settle, compares its answer with an internally computed expectation and keeps tallies.
module alu_op_checker #(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        op_valid,
    output logic        op_ready,
    input  logic [2:0]  op_code,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    output logic        alu_as,
    output logic        alu_sub,
    output logic        alu_shift,
    output logic        alu_shift_left,
    output logic        alu_and,
    output logic        alu_or,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    input  logic [31:0] alu_result,
    input  logic        alu_cout,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_pass,
    output logic        rsp_illegal,
    output logic [31:0] rsp_result,
    output logic [31:0] rsp_expect,
    output logic        rsp_cout,
    output logic [15:0] pass_count,
    output logic [15:0] fail_count
);
    typedef enum logic [1:0] {IDLE, DRIVE, REPORT} state_t;

    localparam logic [3:0] LAST = 4'(SETTLE_CYCLES - 1);

    state_t      state, state_nx;
    logic [2:0]  op_r;
    logic [31:0] expect_r;
    logic        cout_exp_r;
    logic [3:0]  cnt;

    logic        accept, rsp_hs, legal, settle_done, addsub_r;
    logic        is_sub;
    logic [32:0] sum;
    logic [31:0] exp_val;

    assign accept      = op_valid & op_ready;
    assign rsp_hs      = rsp_valid & rsp_ready;
    assign legal       = (op_code <= 3'd5);
    assign settle_done = (cnt == LAST);
    assign addsub_r    = (op_r <= 3'd1);
    assign op_ready    = (state == IDLE);
    assign rsp_valid   = (state == REPORT);

    // Expectation is built from the raw request so it can be latched on the accepting edge.
    assign is_sub = (op_code == 3'd1);
    assign sum    = {1'b0, op_a} + {1'b0, is_sub ? ~op_b : op_b} + {32'd0, is_sub};

    always_comb begin
        exp_val = '0;
        case (op_code)
            3'd0, 3'd1: exp_val = sum[31:0];
            3'd2:       exp_val = op_a >> 1;
            3'd3:       exp_val = op_a << 1;
            3'd4:       exp_val = op_a & op_b;
            3'd5:       exp_val = op_a | op_b;
            default:    exp_val = '0;
        endcase
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = legal ? DRIVE : REPORT;
            DRIVE:   if (settle_done) state_nx = REPORT;
            REPORT:  if (rsp_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Controls are only live while the ALU is being driven.
    always_comb begin
        alu_as         = 1'b0;
        alu_sub        = 1'b0;
        alu_shift      = 1'b0;
        alu_shift_left = 1'b0;
        alu_and        = 1'b0;
        alu_or         = 1'b0;
        if (state == DRIVE) begin
            case (op_r)
                3'd0: alu_as = 1'b1;
                3'd1: begin alu_as = 1'b1; alu_sub = 1'b1; end
                3'd2: alu_shift = 1'b1;
                3'd3: begin alu_shift = 1'b1; alu_shift_left = 1'b1; end
                3'd4: alu_and = 1'b1;
                3'd5: alu_or = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            op_r        <= '0;
            expect_r    <= '0;
            cout_exp_r  <= 1'b0;
            cnt         <= '0;
            alu_a       <= '0;
            alu_b       <= '0;
            rsp_pass    <= 1'b0;
            rsp_illegal <= 1'b0;
            rsp_result  <= '0;
            rsp_expect  <= '0;
            rsp_cout    <= 1'b0;
            pass_count  <= '0;
            fail_count  <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                op_r       <= op_code;
                alu_a      <= op_a;
                alu_b      <= op_b;
                expect_r   <= exp_val;
                cout_exp_r <= sum[32];
                cnt        <= '0;
                if (!legal) begin
                    rsp_illegal <= 1'b1;
                    rsp_pass    <= 1'b0;
                    rsp_result  <= '0;
                    rsp_expect  <= '0;
                    rsp_cout    <= 1'b0;
                end
            end
            if (state == DRIVE) begin
                cnt <= cnt + 4'd1;
                if (settle_done) begin
                    rsp_result  <= alu_result;
                    rsp_cout    <= alu_cout;
                    rsp_expect  <= expect_r;
                    rsp_illegal <= 1'b0;
                    rsp_pass    <= (alu_result == expect_r) &&
                                   (!addsub_r || (alu_cout == cout_exp_r));
                end
            end
            if (rsp_hs) begin
                if (rsp_pass) begin
                    if (pass_count != 16'hFFFF) pass_count <= pass_count + 16'd1;
                end else begin
                    if (fail_count != 16'hFFFF) fail_count <= fail_count + 16'd1;
                end
            end
        end
    end
endmodule
